// File: rtl/shift_driver.sv
// shift_driver: bit-plane (binary-coded modulation) sequencer feeding CHAINS parallel '595 chains from a framebuffer.
// Optional debug pass-through is compiled in when SHIFT_DRIVER_DEBUG_EN is defined.
module shift_driver #(
    parameter int unsigned CHAINS    = 36,
    parameter int unsigned CHAIN_LEN = 48,
    parameter int unsigned BITS      = 8,
    parameter int unsigned BASE      = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [15:0]       fb_addr,
    input  logic [7:0]        fb_data,
    input  logic              debug_data_in,
    input  logic              debug_clk_in,
    input  logic              debug_en,
    output logic              oe,
    output logic              rclk,
    output logic              srclk,
    output logic              srclr,
    output logic [CHAINS-1:0] ser
);
    localparam int unsigned MAX_ON = BASE << (BITS - 1);
    localparam int unsigned DW = $clog2(MAX_ON + 1);
    localparam int unsigned CW = $clog2(CHAINS + 2);
    localparam int unsigned IW = (CHAINS > 1) ? $clog2(CHAINS) : 1;
    localparam int unsigned PW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_FETCH,
        ST_SHIFT,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t            state, state_n;
    logic              clr_cnt, clr_cnt_n;
    logic [CW-1:0]     chain, chain_n;
    logic [PW-1:0]     pixel, pixel_n;
    logic [BW-1:0]     plane, plane_n;
    logic [1:0]        phase, phase_n;
    logic [DW-1:0]     disp_cnt, disp_n;
    logic              oe_n, rclk_n, srclk_n, srclr_n;
    logic [CHAINS-1:0] ser_n;
    logic [15:0]       fb_addr_n;
    logic              unused_debug;

    logic              iss_v, dat_v;
    logic [IW-1:0]     iss_c, dat_c;
    logic [CHAINS-1:0] staging;

    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        chain_n      = chain;
        pixel_n      = pixel;
        plane_n      = plane;
        phase_n      = phase;
        disp_n       = disp_cnt;
        oe_n         = oe;
        rclk_n       = 1'b0;
        srclk_n      = 1'b0;
        srclr_n      = srclr;
        ser_n        = ser;
        fb_addr_n    = fb_addr;
        unused_debug = 1'b0;

        // Display timer runs independently so the next plane's fetch/shift overlaps it.
        if (disp_cnt != '0) begin
            disp_n = disp_cnt - DW'(1);
            if (disp_cnt == DW'(1)) oe_n = 1'b1;
        end

        unique case (state)
            ST_CLEAR: begin
                srclr_n   = 1'b0;
                oe_n      = 1'b1;
                disp_n    = '0;
                fb_addr_n = '0;
                ser_n     = '0;
                if (clr_cnt) begin
                    clr_cnt_n = 1'b0;
                    srclr_n   = 1'b1;
                    chain_n   = '0;
                    state_n   = ST_FETCH;
                end else begin
                    clr_cnt_n = 1'b1;
                end
            end
            ST_FETCH: begin
                if (chain < CW'(CHAINS))
                    fb_addr_n = 16'(chain) * 16'(CHAIN_LEN) + 16'(pixel);
                // Two extra cycles drain the RAM latency and the capture register.
                if (chain == CW'(CHAINS + 1)) begin
                    chain_n = '0;
                    phase_n = '0;
                    state_n = ST_SHIFT;
                end else begin
                    chain_n = chain + CW'(1);
                end
            end
            ST_SHIFT: begin
                case (phase)
                    2'd0: begin
                        ser_n   = staging;
                        phase_n = 2'd1;
                    end
                    2'd1: begin
                        srclk_n = 1'b1;
                        phase_n = 2'd2;
                    end
                    default: begin
                        phase_n = 2'd0;
                        if (pixel == '0) begin
                            state_n = ST_WAIT;
                        end else begin
                            pixel_n = pixel - PW'(1);
                            state_n = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_WAIT: begin
                if (disp_cnt == '0) begin
                    rclk_n  = 1'b1;
                    state_n = ST_LATCH;
                end
            end
            ST_LATCH: begin
                oe_n    = 1'b0;
                disp_n  = DW'(BASE << plane);
                plane_n = (plane == BW'(BITS - 1)) ? '0 : plane + BW'(1);
                pixel_n = PW'(CHAIN_LEN - 1);
                chain_n = '0;
                state_n = ST_FETCH;
            end
            default: state_n = ST_CLEAR;
        endcase

`ifdef SHIFT_DRIVER_DEBUG_EN
        if (debug_en) begin
            state_n   = ST_CLEAR;
            clr_cnt_n = 1'b0;
            chain_n   = '0;
            pixel_n   = PW'(CHAIN_LEN - 1);
            plane_n   = '0;
            phase_n   = '0;
            disp_n    = '0;
            fb_addr_n = '0;
            ser_n     = {CHAINS{debug_data_in}};
            srclk_n   = debug_clk_in;
            rclk_n    = debug_clk_in;
            oe_n      = 1'b0;
            srclr_n   = 1'b1;
        end
`else
        unused_debug = ^{debug_data_in, debug_clk_in, debug_en};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= 1'b0;
            chain    <= '0;
            pixel    <= PW'(CHAIN_LEN - 1);
            plane    <= '0;
            phase    <= '0;
            disp_cnt <= '0;
            oe       <= 1'b1;
            rclk     <= 1'b0;
            srclk    <= 1'b0;
            srclr    <= 1'b0;
            ser      <= '0;
            fb_addr  <= '0;
        end else begin
            state    <= state_n;
            clr_cnt  <= clr_cnt_n;
            chain    <= chain_n;
            pixel    <= pixel_n;
            plane    <= plane_n;
            phase    <= phase_n;
            disp_cnt <= disp_n;
            oe       <= oe_n;
            rclk     <= rclk_n;
            srclk    <= srclk_n;
            srclr    <= srclr_n;
            ser      <= ser_n;
            fb_addr  <= fb_addr_n;
        end
    end

    // Chain index follows its address through the registered address and the RAM output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_v   <= 1'b0;
            iss_c   <= '0;
            dat_v   <= 1'b0;
            dat_c   <= '0;
            staging <= '0;
        end else begin
            iss_v <= (state == ST_FETCH) && (chain < CW'(CHAINS));
            iss_c <= IW'(chain);
            dat_v <= iss_v;
            dat_c <= iss_c;
            if (dat_v) staging[dat_c] <= fb_data[plane];
        end
    end
endmodule

// File: tb/tb_shift_driver.sv
// Self-checking bench for shift_driver: framebuffer model, per-plane shift/latch/display checks, reset abort.
module tb_shift_driver;
    localparam int unsigned CH   = 36;
    localparam int unsigned CL   = 48;
    localparam int unsigned NB   = 8;
    localparam int unsigned BS   = 4;
    localparam int unsigned NPIX = CH * CL;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   fb_addr;
    logic [7:0]    fb_data;
    logic          debug_data_in, debug_clk_in, debug_en;
    logic          oe, rclk, srclk, srclr;
    logic [CH-1:0] ser;

    logic [7:0]    fbm [0:NPIX-1];
    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;

    shift_driver #(.CHAINS(CH), .CHAIN_LEN(CL), .BITS(NB), .BASE(BS)) dut (
        .clk(clk), .rst(rst), .fb_addr(fb_addr), .fb_data(fb_data),
        .debug_data_in(debug_data_in), .debug_clk_in(debug_clk_in), .debug_en(debug_en),
        .oe(oe), .rclk(rclk), .srclk(srclk), .srclr(srclr), .ser(ser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fb_addr < 16'(NPIX)) fb_data <= fbm[fb_addr];
        else fb_data <= 'x;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_oe"}, 64'(oe), 64'(1));
        chk({tag, "_rclk"}, 64'(rclk), 64'(0));
        chk({tag, "_srclk"}, 64'(srclk), 64'(0));
        chk({tag, "_srclr"}, 64'(srclr), 64'(0));
        chk({tag, "_ser"}, 64'(ser), 64'(0));
        chk({tag, "_fb_addr"}, 64'(fb_addr), 64'(0));
    endtask

    // Called #1 after the rising edge at which the sequencer was released.
    task automatic check_restart(input bit from_reset);
        int unsigned waited = 0;
        if (from_reset) begin
            @(negedge clk);
            chk("restart_srclr_c0", 64'(srclr), 64'(0));
            chk("restart_oe", 64'(oe), 64'(1));
        end
        @(negedge clk);
        chk("restart_srclr_c1", 64'(srclr), 64'(0));
        @(negedge clk);
        chk("restart_srclr_high", 64'(srclr), 64'(1));
        while (fb_addr == 16'd0 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("first_fb_addr", 64'(fb_addr), 64'(47));
    endtask

    // Model: plane b shifts pixels CL-1..0; each pulse carries bit b of fb[c*CL+p] on chain c.
    task automatic run_planes(input int unsigned n, input bit directed);
        int unsigned   b = 0, p = CL - 1, pulses = 0, done = 0, idle = 0;
        int unsigned   oe_len = 0, exp_on = 0, disp_plane = 0;
        bit            after_rclk = 1'b0;
        logic [CH-1:0] exp_ser;
        logic [7:0]    pix;
        while (done < n && idle < 3000) begin
            @(negedge clk);
            idle++;
            chk("fb_addr_range", 64'(fb_addr < 16'(NPIX)), 64'(1));
            if (after_rclk) begin
                chk("oe_low_after_rclk", 64'(oe), 64'(0));
                after_rclk = 1'b0;
            end
            if (oe == 1'b0) begin
                oe_len++;
            end else if (oe_len != 0) begin
                chk("oe_low_len", 64'(oe_len), 64'(exp_on));
                if (directed && disp_plane == 7) chk("p7_oe_low_512", 64'(oe_len), 64'(512));
                if (directed && disp_plane == 0) chk("p0_oe_low_4", 64'(oe_len), 64'(4));
                oe_len = 0;
            end
            if (srclk) begin
                chk("no_srclk_with_rclk", 64'(rclk), 64'(0));
                for (int c = 0; c < CH; c++) begin
                    pix = fbm[c * CL + p];
                    exp_ser[c] = pix[b];
                end
                chk("ser_plane_pixel", 64'(ser), 64'(exp_ser));
                if (directed && done < NB && b == 0 && pulses == 0)
                    chk("p0_first_ser_ones", 64'(ser), 64'({CH{1'b1}}));
                if (directed && done < NB && b == 0 && pulses == 1)
                    chk("p0_second_ser_zeros", 64'(ser), 64'(0));
                if (directed && b == 7 && pulses == 0) begin
                    chk("p7_first_ser0", 64'(ser[0]), 64'(0));
                    chk("p7_first_ser3", 64'(ser[3]), 64'(1));
                end
                pulses++;
                p = (p == 0) ? CL - 1 : p - 1;
                idle = 0;
            end
            if (rclk) begin
                chk("pulses_per_plane", 64'(pulses), 64'(CL));
                exp_on     = BS << b;
                disp_plane = b;
                b          = (b + 1) % NB;
                p          = CL - 1;
                pulses     = 0;
                after_rclk = 1'b1;
                done++;
                idle = 0;
            end
        end
        chk("planes_completed", 64'(done), 64'(n));
    endtask

    initial begin
        int unsigned k, seen;
        rst = 1'b1;
        debug_data_in = 1'b0;
        debug_clk_in  = 1'b0;
        debug_en      = 1'b0;
        for (int i = 0; i < NPIX; i++) fbm[i] = 8'(i);

        repeat (3) @(negedge clk);
        check_reset("reset_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        check_restart(1'b1);
        run_planes(9, 1'b1);

        // Abort in the middle of a plane's shifting with reset, then restart on random content.
        k = $urandom_range(3, 40);
        seen = 0;
        for (int i = 0; i < 3000 && seen < k; i++) begin
            @(negedge clk);
            if (srclk) seen++;
        end
        chk("abort_reached_shift", 64'(seen), 64'(k));
        #1 rst = 1'b1;
        #1 check_reset("async_abort");
        for (int i = 0; i < NPIX; i++) fbm[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset("reset_hold2");
        @(posedge clk);
        #1 rst = 1'b0;
        check_restart(1'b1);
        run_planes(2, 1'b0);

`ifdef SHIFT_DRIVER_DEBUG_EN
        @(posedge clk);
        #1;
        debug_en      = 1'b1;
        debug_data_in = 1'b1;
        debug_clk_in  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("dbg_srclk", 64'(srclk), 64'(debug_clk_in));
            chk("dbg_rclk", 64'(rclk), 64'(debug_clk_in));
            chk("dbg_ser", 64'(ser), 64'({CH{1'b1}}));
            chk("dbg_oe", 64'(oe), 64'(0));
            chk("dbg_srclr", 64'(srclr), 64'(1));
            debug_clk_in = ~debug_clk_in;
        end
        @(posedge clk);
        #1;
        debug_en     = 1'b0;
        debug_clk_in = 1'b0;
        check_restart(1'b0);
        run_planes(1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
